// File: rtl/vend_coin_acceptor.sv
// Coin-acceptor front end: measures coin-sensor pulse widths, classifies them, queues accepted coins
// and emits single-cycle coin codes under consumer flow control. Optional tally via VEND_COIN_TALLY_EN.
module vend_coin_acceptor #(
  parameter int unsigned W_MIN05 = 4,
  parameter int unsigned W_MAX05 = 7,
  parameter int unsigned W_MIN10 = 10,
  parameter int unsigned W_MAX10 = 15,
  parameter int unsigned CNT_W   = 6,
  parameter int unsigned QDEPTH  = 4
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       coin_sense,
  input  logic       coin_hold,
  output logic [1:0] coin,
  output logic       reject,
  output logic       jam,
  output logic [7:0] tally
);

  localparam int unsigned AW  = $clog2(QDEPTH);
  localparam int unsigned QCW = AW + 1;
  localparam logic [CNT_W-1:0] CNT_SAT = '1;

  typedef enum logic [1:0] {ST_ARM, ST_IDLE, ST_MEAS, ST_JAM} state_e;

  logic              s1_q, s2_q;
  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              push_c, bad_c, pop_c, push_ok_c, drop_c;
  logic [1:0]        push_code_c;
  logic [QCW-1:0]    q_cnt_q, q_cnt_d;
  logic [AW-1:0]     rd_ptr_q, wr_ptr_q;
  logic [1:0]        mem_q [QDEPTH];
  logic [1:0]        coin_q, coin_d;
  logic              reject_q, reject_d;
  logic              jam_q, jam_d;

  // Synchronizer resets high so ARM only leaves after a genuine low is seen.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      s1_q <= 1'b1;
      s2_q <= 1'b1;
    end else begin
      s1_q <= coin_sense;
      s2_q <= s1_q;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= ST_ARM;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_ARM: begin
        if (!s2_q) state_d = ST_IDLE;
      end
      ST_IDLE: begin
        if (s2_q) begin
          state_d = ST_MEAS;
          cnt_d   = CNT_W'(1);
        end
      end
      ST_MEAS: begin
        if (s2_q) begin
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_d == CNT_SAT) state_d = ST_JAM;
        end else begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end
      end
      ST_JAM: begin
        if (!s2_q) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end
      end
      default: state_d = ST_ARM;
    endcase
  end

  // Classification on pulse end; jam end always rejects.
  always_comb begin
    push_c      = 1'b0;
    push_code_c = 2'b00;
    bad_c       = 1'b0;
    case (state_q)
      ST_MEAS: begin
        if (!s2_q) begin
          if (cnt_q >= CNT_W'(W_MIN05) && cnt_q <= CNT_W'(W_MAX05)) begin
            push_c      = 1'b1;
            push_code_c = 2'b01;
          end else if (cnt_q >= CNT_W'(W_MIN10) && cnt_q <= CNT_W'(W_MAX10)) begin
            push_c      = 1'b1;
            push_code_c = 2'b10;
          end else begin
            bad_c = 1'b1;
          end
        end
      end
      ST_JAM: bad_c = !s2_q;
      default: ;
    endcase
  end

  // Queue control; a same-cycle pop frees a slot for a push into a full queue.
  always_comb begin
    pop_c     = (q_cnt_q != '0) && !coin_hold && (coin_q == 2'b00);
    push_ok_c = push_c && ((q_cnt_q != QCW'(QDEPTH)) || pop_c);
    drop_c    = push_c && !push_ok_c;
    q_cnt_d   = q_cnt_q;
    if (push_ok_c && !pop_c) q_cnt_d = q_cnt_q + QCW'(1);
    else if (pop_c && !push_ok_c) q_cnt_d = q_cnt_q - QCW'(1);
    coin_d   = pop_c ? mem_q[rd_ptr_q] : 2'b00;
    reject_d = bad_c || drop_c;
    jam_d    = (state_d == ST_JAM);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      q_cnt_q  <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      for (int unsigned i = 0; i < QDEPTH; i++) mem_q[i] <= 2'b00;
      coin_q   <= 2'b00;
      reject_q <= 1'b0;
      jam_q    <= 1'b0;
    end else begin
      q_cnt_q <= q_cnt_d;
      if (push_ok_c) begin
        mem_q[wr_ptr_q] <= push_code_c;
        wr_ptr_q        <= wr_ptr_q + AW'(1);
      end
      if (pop_c) rd_ptr_q <= rd_ptr_q + AW'(1);
      coin_q   <= coin_d;
      reject_q <= reject_d;
      jam_q    <= jam_d;
    end
  end

  assign coin   = coin_q;
  assign reject = reject_q;
  assign jam    = jam_q;

`ifdef VEND_COIN_TALLY_EN
  // Code value equals its worth in 0.5 units.
  logic [7:0] tally_q;
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) tally_q <= 8'd0;
    else       tally_q <= tally_q + 8'(coin_d);
  end
  assign tally = tally_q;
`else
  assign tally = 8'd0;
`endif

endmodule
